// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding and default sizes.
// The optional checksum word is enabled by defining REGDUMP_CSUM_EN.
package regfile_dump_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/regdump_xor_acc.sv
// Running XOR of every word dumped; used for the trailing checksum word when REGDUMP_CSUM_EN is defined.
// clear has priority over enable so a new dump always starts from zero.
module regdump_xor_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses 0..NUM_REGS-1 on a start pulse and streams each word over valid/ready.
// Define REGDUMP_CSUM_EN to append an XOR checksum word (adds the dout_is_csum port).
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
`ifdef REGDUMP_CSUM_EN
  ,
  output logic              dout_is_csum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_d;
  logic [ADDR_W-1:0] didx_d;
  logic              valid_d;
  logic              last_d;
  logic              at_last;

  assign at_last = (idx_q == LAST_IDX);
  assign rf_addr = (state_q == ST_IDLE) ? '0 : idx_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FIN);

`ifdef REGDUMP_CSUM_EN
  logic              csum_d;
  logic              acc_clr;
  logic              acc_en;
  logic [DATA_W-1:0] acc_q;

  // The accumulator folds in each word at the same edge the word is captured for output.
  regdump_xor_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clr),
    .enable (acc_en),
    .din    (rf_data),
    .acc    (acc_q)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      dout_data    <= '0;
      dout_idx     <= '0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
`ifdef REGDUMP_CSUM_EN
      dout_is_csum <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dout_data    <= data_d;
      dout_idx     <= didx_d;
      dout_valid   <= valid_d;
      dout_last    <= last_d;
`ifdef REGDUMP_CSUM_EN
      dout_is_csum <= csum_d;
`endif
    end
  end

  // Output registers hold their value unless a state explicitly reloads them, so a stalled word stays put.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = dout_data;
    didx_d  = dout_idx;
    valid_d = dout_valid;
    last_d  = dout_last;
`ifdef REGDUMP_CSUM_EN
    csum_d  = dout_is_csum;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_LOAD;
`ifdef REGDUMP_CSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        data_d  = rf_data;
        didx_d  = idx_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CSUM_EN
        last_d  = 1'b0;
        acc_en  = 1'b1;
`else
        last_d  = at_last;
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          if (at_last) begin
`ifdef REGDUMP_CSUM_EN
            data_d  = acc_q;
            didx_d  = '0;
            valid_d = 1'b1;
            last_d  = 1'b1;
            csum_d  = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
`ifdef REGDUMP_CSUM_EN
      ST_CSUM: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          csum_d  = 1'b0;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
